seq_tracker_fsm: RTL and testbench

SEQ_TRACKER_FSM -- requirements
Module: seq_tracker_fsm

---
 rtl/seq_fsm_pkg.sv | 26 ++
 rtl/seq_fsm_idle_timer.sv | 32 +++
 rtl/seq_tracker_fsm.sv | 105 ++++++++++
 tb/tb_seq_tracker_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_fsm_pkg.sv
// Shared types and helpers for the sequence tracker FSM.
package seq_fsm_pkg;

  typedef enum logic [1:0] {
    ENC_BINARY = 2'd0,
    ENC_GRAY   = 2'd1,
    ENC_ONEHOT = 2'd2
  } enc_e;

  // Helpers work on a fixed 8-bit view: state indices and symbols never exceed it.
  localparam int SYM_W      = 8;
  localparam int MAX_STATES = 256;
  localparam int WRAP_SAT   = 255;

  // Symbol expected in state k: k mod 2^in_w.
  function automatic logic [SYM_W-1:0] exp_sym(input logic [SYM_W-1:0] k, input int in_w);
    logic [SYM_W-1:0] mask;
    mask = SYM_W'((1 << in_w) - 1);
    return k & mask;
  endfunction

  function automatic logic [SYM_W-1:0] bin2gray(input logic [SYM_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/seq_fsm_idle_timer.sv
// Idle-cycle counter with timeout compare for the sequence tracker.
module seq_fsm_idle_timer
  import seq_fsm_pkg::*;
#(
  parameter  int TIMEOUT = 4,
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
)(
  input  logic clk,
  input  logic reset,
  input  logic advance,   // matching symbol consumed this cycle
  input  logic restart,   // strict-mode mismatch sends the FSM to state 0
  input  logic idle_en,   // current state is a legal non-zero state
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;

  // An advance in the final idle cycle wins over the timeout; a strict
  // restart does not, so both events can be flagged together.
  assign expire = idle_en && !advance && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Count idle cycles; any state change or sitting in state 0 clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else if (advance || restart || !idle_en || expire)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/seq_tracker_fsm.sv
// Tracks an incrementing symbol sequence; flags wraps, mismatches and idle timeouts.
module seq_tracker_fsm
  import seq_fsm_pkg::*;
#(
  parameter  int   NUM_STATES = 32,
  parameter  int   IN_W       = 2,
  parameter  enc_e ENCODING   = ENC_BINARY,
  parameter  int   STRICT     = 0,
  parameter  int   TIMEOUT    = 0,
  localparam int   IDX_W      = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
  localparam int   CODE_W     = (ENCODING == ENC_ONEHOT) ? NUM_STATES : IDX_W
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in,
  output logic [IDX_W-1:0]  state_idx,
  output logic [CODE_W-1:0] state_code,
  output logic              out_signal,
  output logic              wrap_pulse,
  output logic              mismatch_pulse,
  output logic              timeout_pulse,
  output logic [7:0]        wrap_count
);

  (* keep = "true" *) logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic in_range, sym_hit, advance, mismatch, last, restart, idle_en, expire;

  function automatic logic [CODE_W-1:0] encode(input logic [IDX_W-1:0] v);
    logic [CODE_W-1:0] c;
    case (ENCODING)
      ENC_GRAY:   c = CODE_W'(bin2gray(SYM_W'(v)));
      ENC_ONEHOT: c = CODE_W'(1) << v;
      default:    c = CODE_W'(v);
    endcase
    return c;
  endfunction

  // XOR of index bits [2:0]; bits above IDX_W read as zero.
  function automatic logic par3(input logic [IDX_W-1:0] v);
    logic [SYM_W-1:0] w;
    w = SYM_W'(v);
    return ^w[2:0];
  endfunction

  assign in_range = int'(idx_q) < NUM_STATES;
  assign sym_hit  = (SYM_W'(in) == exp_sym(SYM_W'(idx_q), IN_W));
  assign advance  = in_range && in_valid && sym_hit;
  assign mismatch = in_range && in_valid && !sym_hit;
  assign last     = int'(idx_q) == NUM_STATES - 1;
  assign restart  = mismatch && (STRICT != 0);
  assign idle_en  = in_range && (idx_q != '0);

  generate
    if (TIMEOUT > 0) begin : g_timer
      seq_fsm_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .restart (restart),
        .idle_en (idle_en),
        .expire  (expire)
      );
    end else begin : g_no_timer
      assign expire = 1'b0;
    end
  endgenerate

  // Next-state selection: illegal index recovery, advance, then restart/timeout.
  always_comb begin
    idx_d = idx_q;
    if (!in_range)
      idx_d = '0;
    else if (advance)
      idx_d = last ? '0 : idx_q + 1'b1;
    else if (restart || expire)
      idx_d = '0;
  end

  // State register plus all registered outputs derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q          <= '0;
      state_code     <= encode('0);
      out_signal     <= 1'b0;
      wrap_pulse     <= 1'b0;
      mismatch_pulse <= 1'b0;
      timeout_pulse  <= 1'b0;
      wrap_count     <= '0;
    end else begin
      idx_q          <= idx_d;
      state_code     <= encode(idx_d);
      out_signal     <= par3(idx_d);
      wrap_pulse     <= advance && last;
      mismatch_pulse <= mismatch;
      timeout_pulse  <= expire;
      if (advance && last && wrap_count != 8'(WRAP_SAT))
        wrap_count <= wrap_count + 8'd1;
    end
  end

  assign state_idx = idx_q;

endmodule

// File: tb/tb_seq_tracker_fsm.sv
// Randomized and directed bench for seq_tracker_fsm against a behavioural model.
module tb_seq_tracker_fsm;
  import seq_fsm_pkg::*;

  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [2:0] in = '0;
  always #5 clk = ~clk;

  // d0: defaults. d1: strict, timeout 4, gray. d2: 12 states, 3-bit symbols, one-hot, timeout 3.
  localparam int NS [3] = '{32, 32, 12};
  localparam int IW [3] = '{2, 2, 3};
  localparam int ST [3] = '{0, 1, 0};
  localparam int TO [3] = '{0, 4, 3};
  localparam int EN [3] = '{0, 1, 2};

  logic [4:0]  i0, c0, i1, c1;
  logic [3:0]  i2;
  logic [11:0] c2;
  logic o0, w0, m0, t0, o1, w1, m1, t1, o2, w2, m2, t2;
  logic [7:0] wc0, wc1, wc2;

  seq_tracker_fsm u_d0 (.clk(clk), .reset(reset), .in_valid(in_valid), .in(in[1:0]),
    .state_idx(i0), .state_code(c0), .out_signal(o0), .wrap_pulse(w0),
    .mismatch_pulse(m0), .timeout_pulse(t0), .wrap_count(wc0));

  seq_tracker_fsm #(.NUM_STATES(32), .IN_W(2), .ENCODING(ENC_GRAY), .STRICT(1), .TIMEOUT(4)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in[1:0]),
    .state_idx(i1), .state_code(c1), .out_signal(o1), .wrap_pulse(w1),
    .mismatch_pulse(m1), .timeout_pulse(t1), .wrap_count(wc1));

  seq_tracker_fsm #(.NUM_STATES(12), .IN_W(3), .ENCODING(ENC_ONEHOT), .STRICT(0), .TIMEOUT(3)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .state_idx(i2), .state_code(c2), .out_signal(o2), .wrap_pulse(w2),
    .mismatch_pulse(m2), .timeout_pulse(t2), .wrap_count(wc2));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position in sequence, idle cycles since last change, wrap tally.
  typedef struct { int idx; int idle; int wc; bit wp; bit mp; bit tp; } mdl_t;
  mdl_t md [3];

  function automatic mdl_t mstep(input mdl_t m, input int k, input bit v, input int sym);
    mdl_t r;
    bit adv, mis, to;
    r = m; r.wp = 0; r.mp = 0; r.tp = 0;
    if (m.idx >= NS[k]) begin r.idx = 0; r.idle = 0; return r; end
    adv = v && (sym == m.idx % (1 << IW[k]));
    mis = v && !adv;
    to  = (TO[k] > 0) && (m.idx != 0) && !adv && (m.idle + 1 >= TO[k]);
    if (adv) begin
      r.idx = (m.idx + 1) % NS[k];
      if (r.idx == 0) begin r.wp = 1; if (r.wc < 255) r.wc = r.wc + 1; end
    end else if ((mis && ST[k] != 0) || to) r.idx = 0;
    r.mp = mis; r.tp = to;
    r.idle = (r.idx != m.idx || r.idx == 0) ? 0 : m.idle + 1;
    return r;
  endfunction

  function automatic logic [63:0] ecode(input int k, input int idx);
    case (EN[k])
      1: return 64'(idx ^ (idx >> 1));
      2: return 64'(1) << idx;
      default: return 64'(idx);
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) md[k] = '{0, 0, 0, 0, 0, 0};
    end else begin
      md[0] = mstep(md[0], 0, in_valid, int'(in[1:0]));
      md[1] = mstep(md[1], 1, in_valid, int'(in[1:0]));
      md[2] = mstep(md[2], 2, in_valid, int'(in));
    end
  end

  task automatic cmp_dut(input int k, input logic [63:0] idx, input logic [63:0] code,
                         input logic o, input logic w, input logic m, input logic t,
                         input logic [63:0] wc);
    int p;
    p = (md[k].idx & 1) ^ ((md[k].idx >> 1) & 1) ^ ((md[k].idx >> 2) & 1);
    chk($sformatf("d%0d.idx", k),  idx,     64'(md[k].idx));
    chk($sformatf("d%0d.code", k), code,    ecode(k, md[k].idx));
    chk($sformatf("d%0d.out", k),  64'(o),  64'(p));
    chk($sformatf("d%0d.wrap", k), 64'(w),  64'(md[k].wp));
    chk($sformatf("d%0d.mism", k), 64'(m),  64'(md[k].mp));
    chk($sformatf("d%0d.tout", k), 64'(t),  64'(md[k].tp));
    chk($sformatf("d%0d.wcnt", k), wc,      64'(md[k].wc));
  endtask

  // Every cycle, all three instances against the model.
  always @(negedge clk) begin
    cmp_dut(0, 64'(i0), 64'(c0), o0, w0, m0, t0, 64'(wc0));
    cmp_dut(1, 64'(i1), 64'(c1), o1, w1, m1, t1, 64'(wc1));
    cmp_dut(2, 64'(i2), 64'(c2), o2, w2, m2, t2, 64'(wc2));
  end

  // Present inputs (at posedge+1), then land 1 time unit after the consuming edge.
  task automatic step(input bit v, input int s);
    in_valid = v; in = 3'(s);
    @(posedge clk); #1;
  endtask

  initial begin
    int r;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.idx0", 64'(i0), 64'd0);
    chk("rst.code2_onehot", 64'(c2), 64'h1);
    chk("rst.wcnt0", 64'(wc0), 64'd0);
    reset = 1'b0;

    // Full pass of the default sequence.
    for (int i = 0; i < 32; i++) step(1, i % 4);
    chk("pass.idx0", 64'(i0), 64'd0);
    chk("pass.wrap0", 64'(w0), 64'd1);
    chk("pass.wcnt0", 64'(wc0), 64'd1);
    chk("pass.wcnt1", 64'(wc1), 64'd1);
    chk("pass.model_wc0", 64'(md[0].wc), 64'd1);
    step(0, 0);
    chk("pass.wrap0_drop", 64'(w0), 64'd0);

    // Mismatch in state 5: d0 holds, d1 restarts.
    for (int i = 0; i < 5; i++) step(1, i % 4);
    chk("mis.idx0_at5", 64'(i0), 64'd5);
    step(1, 3);
    chk("mis.idx0_hold", 64'(i0), 64'd5);
    chk("mis.pulse0", 64'(m0), 64'd1);
    chk("mis.idx1_restart", 64'(i1), 64'd0);
    chk("mis.pulse1", 64'(m1), 64'd1);
    step(1, 1);
    chk("mis.idx0_adv", 64'(i0), 64'd6);
    chk("mis.pulse0_drop", 64'(m0), 64'd0);
    step(1, 2);
    chk("mis.idx1_zero", 64'(i1), 64'd0);
    chk("mis.pulse1_again", 64'(m1), 64'd1);

    // Timeout on d1 (TIMEOUT=4) and the advance-wins case.
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1, i);
    repeat (3) step(0, 0);
    chk("to.idx1_before", 64'(i1), 64'd3);
    step(0, 0);
    chk("to.idx1", 64'(i1), 64'd0);
    chk("to.pulse1", 64'(t1), 64'd1);
    chk("to.idx0_holds", 64'(i0), 64'd3);
    step(0, 0);
    chk("to.pulse1_drop", 64'(t1), 64'd0);
    for (int i = 0; i < 3; i++) step(1, i);
    repeat (3) step(0, 0);
    step(1, 3);
    chk("to.adv_idx1", 64'(i1), 64'd4);
    chk("to.adv_nopulse", 64'(t1), 64'd0);

    // Randomized traffic biased toward each instance's expected symbol.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0: in = 3'(md[0].idx % 4);
        1: in = 3'(md[2].idx % 8);
        2: in = 3'(md[1].idx % 4);
        default: in = 3'($urandom_range(0, 7));
      endcase
      in_valid = ($urandom_range(0, 9) != 0);
      @(posedge clk); #1;
    end

    // 256 full passes: wrap_count saturates.
    reset = 1'b1; #1; reset = 1'b0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 32; i++) step(1, i % 4);
      if (p == 254) chk("sat.wcnt0_255", 64'(wc0), 64'd255);
    end
    chk("sat.wcnt0_hold", 64'(wc0), 64'd255);
    chk("sat.wcnt1_hold", 64'(wc1), 64'd255);

    // Asynchronous reset in state 17.
    for (int i = 0; i < 17; i++) step(1, i % 4);
    chk("ar.idx0_at17", 64'(i0), 64'd17);
    #2; reset = 1'b1; #1;
    chk("ar.idx0", 64'(i0), 64'd0);
    chk("ar.code0", 64'(c0), 64'd0);
    chk("ar.out0", 64'(o0), 64'd0);
    chk("ar.wcnt0", 64'(wc0), 64'd0);
    chk("ar.code2", 64'(c2), 64'h1);
    chk("ar.pulses1", {61'd0, w1, m1, t1}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, 0);
    chk("ar.first_edge", 64'(i0), 64'd1);
    step(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
